// File: rtl/vga_sync_if.sv
// vga_sync_if: timing bundle from vga_sync_gen to the VGA port and pixel generator.
//   hsync, vsync   sync levels for the VGA connector
//   video_on       (x,y) is inside the visible area
//   x, y           horizontal / vertical scan counters (SCREEN_WIDTH bits)
//   p_tick         one-sys_clk strobe per pixel advance
//   frame_tick     one-sys_clk strobe at the start of vertical blanking
//   frame_cnt      16-bit frame counter, present only with VGA_SYNC_FRAME_CNT_EN
// master: the sync generator drives everything; slave: consumers read everything.
interface vga_sync_if #(
    parameter int unsigned SCREEN_WIDTH = 10
);
    logic                    hsync;
    logic                    vsync;
    logic                    video_on;
    logic [SCREEN_WIDTH-1:0] x;
    logic [SCREEN_WIDTH-1:0] y;
    logic                    p_tick;
    logic                    frame_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0]             frame_cnt;
`endif

    modport master (
        output hsync, vsync, video_on, x, y, p_tick, frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input hsync, vsync, video_on, x, y, p_tick, frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing source. Divides sys_clk into a pixel tick, runs the
// horizontal/vertical scan counters and produces hsync, vsync, video_on and a
// once-per-frame strobe at the start of vertical blanking.
// Ports:
//   sys_clk   system clock
//   sys_rst   synchronous, active-high reset
//   vga       vga_sync_if.master: hsync, vsync, video_on, x, y, p_tick, frame_tick
// Optional: define VGA_SYNC_FRAME_CNT_EN to add vga.frame_cnt, a 16-bit wrapping
// count of frame_tick pulses.
module vga_sync_gen #(
    parameter int unsigned SCREEN_WIDTH = 10,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter bit          SYNC_ACTIVE  = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    vga_sync_if.master vga
);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [SCREEN_WIDTH-1:0] H_LAST       = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_LAST       = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] H_VIS        = SCREEN_WIDTH'(H_DISPLAY);
    localparam logic [SCREEN_WIDTH-1:0] V_VIS        = SCREEN_WIDTH'(V_DISPLAY);
    // Inclusive sync bounds so an end position equal to the total never overflows.
    localparam logic [SCREEN_WIDTH-1:0] H_SYNC_FIRST = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] H_SYNC_LAST  = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_SYNC_FIRST = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] V_SYNC_LAST  = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]        div_q, div_d;
    logic [SCREEN_WIDTH-1:0] x_q, x_d;
    logic [SCREEN_WIDTH-1:0] y_q, y_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    video_on_q, video_on_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    p_tick_c;

    // Next-state for divider, scan counters and the registered timing outputs.
    always_comb begin
        div_d        = div_q;
        x_d          = x_q;
        y_d          = y_q;
        hsync_d      = ~SYNC_ACTIVE;
        vsync_d      = ~SYNC_ACTIVE;
        video_on_d   = 1'b0;
        frame_tick_d = 1'b0;

        // Gated by reset so a divide-by-one build still reads 0 while held in reset.
        p_tick_c = (div_q == DIV_LAST) && !sys_rst;

        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (p_tick_c) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + SCREEN_WIDTH'(1);
                end
            end else begin
                x_d = x_q + SCREEN_WIDTH'(1);
            end
        end

        // Decoded from the next counter values so the flops line up with x/y.
        if ((x_d >= H_SYNC_FIRST) && (x_d <= H_SYNC_LAST)) begin
            hsync_d = SYNC_ACTIVE;
        end
        if ((y_d >= V_SYNC_FIRST) && (y_d <= V_SYNC_LAST)) begin
            vsync_d = SYNC_ACTIVE;
        end
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);

        // Only the edge that moves the counters onto (0, V_DISPLAY) raises the strobe.
        frame_tick_d = p_tick_c && (x_d == '0) && (y_d == V_VIS);
    end

    // State registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            video_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_on_q;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.p_tick     = p_tick_c;
    assign vga.frame_tick = frame_tick_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts frame_tick pulses; wraps at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif
endmodule
